// File: rtl/lockin_pkg.sv
// Shared types and helpers for the lock-in integration stage.
package lockin_pkg;

    localparam int DATA_W_DEFAULT = 64;
    localparam int ACC_W_DEFAULT  = 96;
    localparam int CNT_W          = 16;

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    function automatic logic signed [ACC_W_DEFAULT-1:0] sign_extend(
        input logic signed [DATA_W_DEFAULT-1:0] d
    );
        return ACC_W_DEFAULT'(d);
    endfunction

endpackage

// File: rtl/lockin_acc_channel.sv
// One integration channel: running sum plus the registered per-window result.
module lockin_acc_channel
    import lockin_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int ACC_W  = ACC_W_DEFAULT
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     load,
    input  logic                     add,
    input  logic                     dump,
    input  logic signed [DATA_W-1:0] data,
    output logic signed [ACC_W-1:0]  acc
);

    logic signed [ACC_W-1:0] ext;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] total;

    if (DATA_W == DATA_W_DEFAULT && ACC_W == ACC_W_DEFAULT) begin : g_pkg_ext
        assign ext = sign_extend(data);
    end else begin : g_rep_ext
        assign ext = {{(ACC_W-DATA_W){data[DATA_W-1]}}, data};
    end

    // A loading sample starts from zero, so the first sample of a window also works for length-1 windows.
    assign total = (load ? '0 : sum) + ext;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sum <= '0;
            acc <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (dump) begin
            acc <= total;
            sum <= '0;
        end else if (load || add) begin
            sum <= total;
        end
    end

endmodule

// File: rtl/lockin_accumulator.sv
// Lock-in integrator: sums I/Q mixer products over whole reference periods and emits one pair per window.
module lockin_accumulator
    import lockin_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int ACC_W  = ACC_W_DEFAULT
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [CNT_W-1:0]         ptos_x_ciclo,
    input  logic [CNT_W-1:0]         ciclos,
    input  logic signed [DATA_W-1:0] data_seno,
    input  logic signed [DATA_W-1:0] data_coseno,
    input  logic                     data_valid,
    output logic signed [ACC_W-1:0]  acc_seno,
    output logic signed [ACC_W-1:0]  acc_coseno,
    output logic                     data_valid_out,
    output logic                     busy
);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] ptos_sh;
    logic [CNT_W-1:0] ciclos_sh;
    logic [CNT_W-1:0] pt_cnt;
    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] ptos_eff;
    logic [CNT_W-1:0] ciclos_eff;
    logic             first;
    logic             cycle_end;
    logic             window_end;
    logic             load;
    logic             add;
    logic             dump;
    logic             clear;

    // A window opened from IDLE uses the live config, since the shadow captures it on that same edge.
    assign ptos_eff   = (state == IDLE) ? ptos_x_ciclo : ptos_sh;
    assign ciclos_eff = (state == IDLE) ? ciclos       : ciclos_sh;
    assign first      = (pt_cnt == '0) && (cyc_cnt == '0);
    assign cycle_end  = ({1'b0, pt_cnt} + 17'd1) == {1'b0, ptos_eff};
    assign window_end = cycle_end && (cyc_cnt == ciclos_eff - 16'd1);

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        add        = 1'b0;
        dump       = 1'b0;
        clear      = 1'b0;
        if (!enable) begin
            state_next = IDLE;
            clear      = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (data_valid && ptos_eff != '0 && ciclos_eff != '0) begin
                        state_next = ACCUM;
                        load       = 1'b1;
                        dump       = window_end;
                    end
                end
                ACCUM: begin
                    if (data_valid) begin
                        load = first;
                        add  = !first;
                        dump = window_end;
                        // A zero config reloaded at window end could never close a window.
                        if (window_end && (ptos_x_ciclo == '0 || ciclos == '0))
                            state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            ptos_sh        <= '0;
            ciclos_sh      <= '0;
            pt_cnt         <= '0;
            cyc_cnt        <= '0;
            data_valid_out <= 1'b0;
        end else begin
            state          <= state_next;
            data_valid_out <= dump;
            if (state == IDLE || dump) begin
                ptos_sh   <= ptos_x_ciclo;
                ciclos_sh <= ciclos;
            end
            if (clear || dump) begin
                pt_cnt  <= '0;
                cyc_cnt <= '0;
            end else if (load || add) begin
                if (cycle_end) begin
                    pt_cnt  <= '0;
                    cyc_cnt <= cyc_cnt + 16'd1;
                end else begin
                    pt_cnt <= pt_cnt + 16'd1;
                end
            end
        end
    end

    assign busy = (state == ACCUM);

    lockin_acc_channel #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_seno (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .load  (load),
        .add   (add),
        .dump  (dump),
        .data  (data_seno),
        .acc   (acc_seno)
    );

    lockin_acc_channel #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_coseno (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .load  (load),
        .add   (add),
        .dump  (dump),
        .data  (data_coseno),
        .acc   (acc_coseno)
    );

endmodule
